// File: rtl/dvp_frame_writer_pkg.sv
// Shared DVP timing and framebuffer constants, plus the capture FSM state encoding.
// The LCD controller imports the same FB constants so both sides agree on the buffer layout.
package dvp_frame_writer_pkg;

    localparam int unsigned SRC_W    = 640;
    localparam int unsigned SRC_H    = 480;
    localparam int unsigned DECIM    = 4;
    localparam int unsigned OUT_W    = SRC_W / DECIM;
    localparam int unsigned OUT_H    = SRC_H / DECIM;
    localparam int unsigned FB_BYTES = OUT_W * OUT_H;
    localparam int unsigned FB_AW    = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2
    } cap_state_t;

endpackage

// File: rtl/dvp_sync.sv
// 2-FF synchronizer bank for the DVP bus (pclk, href, vsync, data) with edge detectors.
// All eleven bits share one register chain so that data and strobes keep equal latency.
module dvp_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cam_pclk,
    input  logic       cam_vsync,
    input  logic       cam_href,
    input  logic [7:0] cam_data,
    output logic       pe,
    output logic       href,
    output logic       href_fall,
    output logic       vsync_rise,
    output logic       vsync_fall,
    output logic [7:0] data
);

    logic [10:0] meta;
    logic [10:0] sync;
    logic        pclk_d;
    logic        href_d;
    logic        vsync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta    <= '0;
            sync    <= '0;
            pclk_d  <= 1'b0;
            href_d  <= 1'b0;
            vsync_d <= 1'b0;
        end else begin
            meta    <= {cam_vsync, cam_href, cam_pclk, cam_data};
            sync    <= meta;
            pclk_d  <= sync[8];
            href_d  <= sync[9];
            vsync_d <= sync[10];
        end
    end

    assign data       = sync[7:0];
    assign pe         = sync[8] & ~pclk_d;
    assign href       = sync[9];
    assign href_fall  = ~sync[9] & href_d;
    assign vsync_rise = sync[10] & ~vsync_d;
    assign vsync_fall = ~sync[10] & vsync_d;

endmodule

// File: rtl/dvp_frame_writer.sv
// Captures decimated luma from a YUYV DVP camera into the grayscale framebuffer BRAM.
// Single-shot or continuous capture; reports frame completion and shape/count errors.
module dvp_frame_writer #(
    parameter int unsigned SRC_W = 640,
    parameter int unsigned SRC_H = 480,
    parameter int unsigned DECIM = 4,
    parameter int unsigned OUT_W = 160,
    parameter int unsigned OUT_H = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cam_pclk,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic        capture_req,
    input  logic        continuous,
    output logic        bram_we,
    output logic [14:0] bram_addr,
    output logic [7:0]  bram_wdata,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_err
);

    import dvp_frame_writer_pkg::*;

    localparam logic [15:0] FB16       = 16'(OUT_W * OUT_H);
    localparam logic [10:0] LINE_BYTES = 11'(2 * SRC_W);
    localparam logic [9:0]  LINES      = 10'(SRC_H);
    localparam logic [10:0] COL_MASK   = 11'(DECIM - 1);
    localparam logic [9:0]  ROW_MASK   = 10'(DECIM - 1);

    cap_state_t  state;
    cap_state_t  next_state;

    logic        pe;
    logic        href;
    logic        href_fall;
    logic        vsync_rise;
    logic        vsync_fall;
    logic [7:0]  data;

    logic [10:0] byte_cnt;
    logic [9:0]  line_cnt;
    logic [15:0] wr_cnt;
    logic        shape_err;

    logic        accept;
    logic        frame_start;
    logic        frame_end;
    logic        line_end;
    logic        byte_en;
    logic        do_write;

    dvp_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .cam_pclk   (cam_pclk),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .pe         (pe),
        .href       (href),
        .href_fall  (href_fall),
        .vsync_rise (vsync_rise),
        .vsync_fall (vsync_fall),
        .data       (data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (capture_req) next_state = ARM;
            ARM:     if (vsync_fall)  next_state = CAPTURE;
            CAPTURE: if (vsync_rise)  next_state = continuous ? ARM : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Luma sits at even byte indices; decimation keeps every DECIM-th column and line.
    always_comb begin
        accept      = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        line_end    = 1'b0;
        byte_en     = 1'b0;
        do_write    = 1'b0;
        case (state)
            IDLE:    accept = capture_req;
            ARM:     frame_start = vsync_fall;
            CAPTURE: begin
                frame_end = vsync_rise;
                line_end  = href_fall;
                byte_en   = pe & href;
                do_write  = pe & href & ~byte_cnt[0]
                          & (((byte_cnt >> 1) & COL_MASK) == 11'd0)
                          & ((line_cnt & ROW_MASK) == 10'd0)
                          & (wr_cnt < FB16);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt  <= '0;
            line_cnt  <= '0;
            wr_cnt    <= '0;
            shape_err <= 1'b0;
        end else if (frame_start) begin
            byte_cnt  <= '0;
            line_cnt  <= '0;
            wr_cnt    <= '0;
            shape_err <= 1'b0;
        end else begin
            if (line_end) begin
                byte_cnt <= '0;
                if (line_cnt != '1) line_cnt <= line_cnt + 10'd1;
                if (byte_cnt != LINE_BYTES || line_cnt >= LINES) shape_err <= 1'b1;
            end else if (byte_en && byte_cnt != '1) begin
                byte_cnt <= byte_cnt + 11'd1;
            end
            // Address advances in the cycle after the strobe, so bram_addr is stable while bram_we is high.
            if (bram_we) wr_cnt <= wr_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_we    <= 1'b0;
            bram_wdata <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            bram_we    <= do_write;
            if (do_write) bram_wdata <= data;
            busy       <= (next_state != IDLE);
            frame_done <= frame_end;
            if (accept) begin
                frame_err <= 1'b0;
            end else if (frame_end && (shape_err || wr_cnt != FB16)) begin
                frame_err <= 1'b1;
            end
        end
    end

    assign bram_addr = wr_cnt[14:0];

endmodule

// File: tb/tb_dvp_frame_writer.sv
// Directed bench for dvp_frame_writer on a reduced 16x12 source, decimated by 4 to a 4x3 buffer.
// A byte-level DVP driver replays frames; writes and frame_done pulses are logged on the falling clock edge.
module tb_dvp_frame_writer;

    localparam int unsigned SW = 16;
    localparam int unsigned SH = 12;
    localparam int unsigned DC = 4;
    localparam int unsigned OW = 4;
    localparam int unsigned OH = 3;
    localparam int unsigned FB = OW * OH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cam_pclk = 1'b0;
    logic        cam_vsync = 1'b1;
    logic        cam_href = 1'b0;
    logic [7:0]  cam_data = 8'h00;
    logic        capture_req = 1'b0;
    logic        continuous = 1'b0;
    logic        bram_we;
    logic [14:0] bram_addr;
    logic [7:0]  bram_wdata;
    logic        busy;
    logic        frame_done;
    logic        frame_err;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned n_fail = 0;
    int unsigned done_cnt = 0;
    logic        err_at_done = 1'b0;
    logic [14:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];

    always #5 clk = ~clk;

    dvp_frame_writer #(
        .SRC_W (SW),
        .SRC_H (SH),
        .DECIM (DC),
        .OUT_W (OW),
        .OUT_H (OH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cam_pclk    (cam_pclk),
        .cam_vsync   (cam_vsync),
        .cam_href    (cam_href),
        .cam_data    (cam_data),
        .capture_req (capture_req),
        .continuous  (continuous),
        .bram_we     (bram_we),
        .bram_addr   (bram_addr),
        .bram_wdata  (bram_wdata),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_err   (frame_err)
    );

    always @(negedge clk) begin
        if (bram_we) begin
            wr_addr_q.push_back(bram_addr);
            wr_data_q.push_back(bram_wdata);
        end
        if (frame_done) begin
            done_cnt++;
            err_at_done = frame_err;
        end
    end

    function automatic logic [7:0] luma(input int unsigned c, input int unsigned l);
        return 8'(c * 3 + l * 5 + 7);
    endfunction

    function automatic logic [7:0] chroma(input int unsigned c);
        return 8'(32'hC0 | c);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pclk_byte(input logic [7:0] d, input logic h, input logic v);
        cam_data  = d;
        cam_href  = h;
        cam_vsync = v;
        #40 cam_pclk = 1'b1;
        #40 cam_pclk = 1'b0;
    endtask

    task automatic pulse_req();
        @(posedge clk);
        #1 capture_req = 1'b1;
        @(posedge clk);
        #1 capture_req = 1'b0;
    endtask

    task automatic reset_mid_frame();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_we",    32'(bram_we),    32'd0);
        check("rst_async_addr",  32'(bram_addr),  32'd0);
        check("rst_async_wdata", 32'(bram_wdata), 32'd0);
        check("rst_async_busy",  32'(busy),       32'd0);
        check("rst_async_done",  32'(frame_done), 32'd0);
        check("rst_async_err",   32'(frame_err),  32'd0);
        #20 rst_n = 1'b1;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    // Lines are numbered from 0; pass -1 to disable any of the mid-frame actions.
    task automatic send_frame(input int nlines, input int short_line, input int req_line,
                              input int rst_line, input int cont_off_line);
        for (int i = 0; i < 4; i++) pclk_byte(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) pclk_byte(8'h00, 1'b0, 1'b0);
        for (int l = 0; l < nlines; l++) begin
            int nbytes;
            nbytes = (l == short_line) ? int'(2 * SW - 2) : int'(2 * SW);
            if (l == cont_off_line) continuous = 1'b0;
            for (int b = 0; b < nbytes; b++) begin
                if (b == int'(SW) && l == req_line) pulse_req();
                if (b == int'(SW) && l == rst_line) reset_mid_frame();
                if (b[0]) pclk_byte(chroma(b >> 1), 1'b1, 1'b0);
                else      pclk_byte(luma(b >> 1, l), 1'b1, 1'b0);
            end
            for (int i = 0; i < 4; i++) pclk_byte(8'h00, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) pclk_byte(8'h00, 1'b0, 1'b1);
        repeat (8) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input int unsigned exp_done, input logic exp_err);
        check({tag, "_nwr"}, 32'(wr_addr_q.size()), 32'(FB));
        for (int a = 0; a < wr_addr_q.size() && a < int'(FB); a++) begin
            check($sformatf("%s_addr%0d", tag, a), 32'(wr_addr_q[a]), 32'(a));
            check($sformatf("%s_data%0d", tag, a), 32'(wr_data_q[a]),
                  32'(luma(DC * (a % OW), DC * (a / OW))));
        end
        check({tag, "_done"}, done_cnt, 32'(exp_done));
        check({tag, "_err"}, 32'(err_at_done), 32'(exp_err));
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        #23;
        check("reset_we",    32'(bram_we),    32'd0);
        check("reset_addr",  32'(bram_addr),  32'd0);
        check("reset_wdata", 32'(bram_wdata), 32'd0);
        check("reset_busy",  32'(busy),       32'd0);
        check("reset_done",  32'(frame_done), 32'd0);
        check("reset_err",   32'(frame_err),  32'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // nominal single frame
        pulse_req();
        @(negedge clk);
        check("nominal_busy_arm", 32'(busy), 32'd1);
        send_frame(SH, -1, -1, -1, -1);
        check_frame("nominal", 1, 1'b0);
        check("nominal_busy_end", 32'(busy), 32'd0);
        check("nominal_addr_sat", 32'(bram_addr), 32'(FB));

        // request arrives mid-frame: that frame is skipped, the next is captured
        send_frame(SH, -1, 5, -1, -1);
        check("midarm_nowr", 32'(wr_addr_q.size()), 32'd0);
        check("midarm_nodone", done_cnt, 32'd1);
        check("midarm_busy", 32'(busy), 32'd1);
        send_frame(SH, -1, -1, -1, -1);
        check_frame("midarm", 2, 1'b0);

        // short line flags an error; the next accepted request clears it
        pulse_req();
        send_frame(SH, 3, -1, -1, -1);
        check_frame("short", 3, 1'b1);
        check("short_err_sticky", 32'(frame_err), 32'd1);
        pulse_req();
        @(negedge clk);
        check("short_err_cleared", 32'(frame_err), 32'd0);
        send_frame(SH, -1, -1, -1, -1);
        check_frame("after_short", 4, 1'b0);

        // continuous mode over three frames, dropped during the third
        continuous = 1'b1;
        pulse_req();
        send_frame(SH, -1, -1, -1, -1);
        check_frame("cont1", 5, 1'b0);
        check("cont1_busy", 32'(busy), 32'd1);
        send_frame(SH, -1, -1, -1, -1);
        check_frame("cont2", 6, 1'b0);
        check("cont2_busy", 32'(busy), 32'd1);
        send_frame(SH, -1, -1, -1, 2);
        check_frame("cont3", 7, 1'b0);
        check("cont3_busy", 32'(busy), 32'd0);
        send_frame(SH, -1, -1, -1, -1);
        check("cont_idle_nowr", 32'(wr_addr_q.size()), 32'd0);
        check("cont_idle_nodone", done_cnt, 32'd7);

        // too many lines: writes cap at the buffer size and the frame is flagged
        pulse_req();
        send_frame(SH + 4, -1, -1, -1, -1);
        check_frame("overlong", 8, 1'b1);
        check("overlong_addr_sat", 32'(bram_addr), 32'(FB));

        // reset partway through a captured frame
        pulse_req();
        send_frame(SH, -1, -1, 6, -1);
        check("rst_nowr", 32'(wr_addr_q.size()), 32'd0);
        check("rst_nodone", done_cnt, 32'd8);
        check("rst_busy", 32'(busy), 32'd0);
        send_frame(SH, -1, -1, -1, -1);
        check("rst_idle_nowr", 32'(wr_addr_q.size()), 32'd0);
        check("rst_idle_nodone", done_cnt, 32'd8);
        check("rst_idle_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dvp_frame_writer.md
# dvp_frame_writer

Camera-side writer for the grayscale framebuffer BRAM that the LCD controller reads. It oversamples an 8-bit DVP camera bus (YUYV 4:2:2 output) in the 27 MHz system domain and keeps only the luma bytes. It decimates the image by DECIM in both axes and writes the resulting OUT_W×OUT_H bytes linearly from address 0. Captures run one frame per request or continuously, and a completion pulse plus error flag go to the system controller.

## Interface
- SRC_W, 640: camera active pixels per line (2·SRC_W bytes per href).
- SRC_H, 480: camera active lines per frame.
- DECIM, 4: decimation factor, power of two, both axes.
- OUT_W, 160: output width, SRC_W/DECIM.
- OUT_H, 120: output height, SRC_H/DECIM; OUT_W·OUT_H ≤ 32768.

Ports:
- clk  in  1  27 MHz system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cam_pclk  in  1  camera pixel clock, asynchronous, ≤ 4.5 MHz.
- cam_vsync  in  1  frame sync, active-high during vertical blank.
- cam_href  in  1  line valid, active-high.
- cam_data  in  8  DVP data, valid on cam_pclk rising edge.
- capture_req  in  1  1-cycle start pulse.
- continuous  in  1  when high, re-arm automatically after each frame.
- bram_we  out  1  write strobe.
- bram_addr  out  15  write address.
- bram_wdata  out  8  luma byte.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  1-cycle pulse at end of a captured frame.
- frame_err  out  1  sticky error flag; cleared when a new capture is accepted.

## Operation
- cam_pclk, cam_vsync, cam_href and cam_data each pass through a 2-FF synchronizer. All paths share the same latency.
- A pixel event, pe, is a 0→1 transition of the synchronized pclk. Its data is the synchronized byte in the same cycle.
- IDLE: accept capture_req. On acceptance, clear frame_err and go to ARM.
- ARM: wait for a synchronized vsync falling edge, which marks the frame start. Clear all counters and bram_addr, then go to CAPTURE.
- CAPTURE:
  - On pe with href high, byte_cnt increments.
  - A byte is luma when byte_cnt[0]==0.
  - The pixel column is col = byte_cnt>>1.
  - Write the byte when all of these hold: it is luma, col%DECIM==0, line_cnt%DECIM==0, and bram_addr < OUT_W·OUT_H.
- On a synchronized href falling edge, line_cnt increments and byte_cnt clears.
- bram_addr increments after each write and saturates at OUT_W·OUT_H; no write ever occurs at or beyond it.
- A synchronized vsync rising edge in CAPTURE ends the frame:
  - frame_done pulses.
  - frame_err is set if the write count ≠ OUT_W·OUT_H.
  - frame_err is also set if any line held ≠ 2·SRC_W bytes, or if href was high beyond SRC_H lines.
  - Then go to ARM if continuous is high, else IDLE.
- capture_req while busy is ignored.
- Clearing continuous mid-frame lets the current frame finish, then the block goes to IDLE.
- Async reset at any point returns to IDLE. All outputs go to 0 immediately and the partial frame is abandoned.

## Timing
- Reset values: bram_we=0, bram_addr=0, bram_wdata=0, busy=0, frame_done=0, frame_err=0.
- Input-to-write latency: bram_we, bram_addr and bram_wdata are registered together one clk after the pe cycle, which is 3–4 clk after the external pclk edge.
- bram_we is high for exactly one clk per write.
- The minimum pe spacing is 6 clk, so successive writes are always separated by at least 5 idle cycles.
- frame_done asserts one clk after the vsync-rising detection cycle.
- busy rises in the clk after capture_req is accepted and falls in the same cycle frame_done asserts when returning to IDLE.
- Width rules:
  - byte_cnt is 11 bits and saturates at 2047.
  - line_cnt is 10 bits and saturates at 1023.
  - The saturated count is compared against the limit for the error check.

## Structure
- Shared package: DVP timing constants (SRC_W, SRC_H, DECIM), framebuffer size constant FB_BYTES=OUT_W·OUT_H, and the state encoding IDLE/ARM/CAPTURE. The LCD side uses the same FB constants.
- One natural sub-module, dvp_sync: the 11-bit 2-FF synchronizer bank plus pclk/href/vsync edge detectors. It outputs pe, href_fall, vsync_rise, vsync_fall and the data byte.

## Test plan
- Nominal frame: capture_req with a 640×480 BFM, pclk 3 MHz, luma = (col+line)&0xFF. Require exactly 19200 writes at addr 0..19199, byte at addr a = (4·(a%160) + 4·(a/160))&0xFF, frame_done once, frame_err=0, busy low afterwards.
- Mid-frame arm: capture_req asserted during href of line 100. Require no writes until the next vsync falling edge, then one complete frame.
- Short line: line 37 carries 1278 bytes. Require frame_err=1 at frame_done, no write address ≥ 19200, and frame_err cleared by the next capture_req.
- Continuous mode: continuous=1 over 3 frames, deasserted during frame 3. Require 3 frame_done pulses, bram_addr restarting at 0 each frame, and IDLE after frame 3.
- Overlong frame: 500 lines of href. Require writes capped at 19200 and frame_err=1.
- Reset mid-CAPTURE: rst_n low at line 200. Require all outputs 0 asynchronously, IDLE after release, and no writes without a new capture_req.
